ysyx_22050854_mul_ctrl: RTL and testbench
=========================================

YSYX_22050854_MUL_CTRL -- requirements
Module: ysyx_22050854_mul_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have port mul_valid, input, 1, request strobe from the EXU.
REQ-004 SHALL have port flush, input, 1, abort any operation in flight.
REQ-005 SHALL have port mulw, input, 1, 32-bit operation (RV64 MULW).
REQ-006 SHALL have port mul_signed, input, 2, {multiplicand signed, multiplier signed}.
REQ-007 SHALL have port multiplicand, input, 64, operand X.
REQ-008 SHALL have port multiplier, input, 64, operand Y.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port mul_ready, output, 1, controller can accept a request.
REQ-011 SHALL have port out_valid, output, 1, result_hi/result_lo valid.
REQ-012 SHALL have port result_hi, output, 64, upper 64 bits of the product.
REQ-013 SHALL have port result_lo, output, 64, lower 64 bits of the product.

Function
REQ-014 SHALL implement FSM IDLE, BUSY, DONE; mul_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL accept a request on a clock edge with state==IDLE, mul_valid=1, flush=0, and latch operands, mul_signed and mulw, then go to BUSY.
REQ-016 SHALL extend the operands to 66 bits: sign-extend if the corresponding mul_signed bit is 1, else zero-extend; mul_signed=2'b01 SHALL be treated as 2'b00.
REQ-017 SHALL, when mulw=1, use only operand bits [31:0], extended to 34 bits per REQ-016.
REQ-018 SHALL hold X sign-extended to 132 bits in a shift register that shifts left by 2 each BUSY cycle.
REQ-019 SHALL hold Y with an appended LSB of 0 in a shift register that shifts right by 2 each BUSY cycle, supplying the 3-bit Booth window {y[i+1], y[i], y[i-1]}.
REQ-020 SHALL, each BUSY cycle, form the partial product and its carry-in using the Booth radix-4 partial-product generator (window, 132-bit X in; p, c out), and add both to a 132-bit accumulator modulo 2^132.
REQ-021 SHALL count iterations with a 6-bit counter: 33 BUSY cycles for 64-bit operations, 17 for mulw; after the last iteration, go to DONE.
REQ-022 SHALL produce result_lo = acc[63:0] and result_hi = acc[127:64] for 64-bit operations.
REQ-023 SHALL produce result_lo = sign-extension of acc[31:0] to 64 bits and result_hi = 0 for mulw.
REQ-024 SHALL hold result_hi/result_lo stable while out_valid=1.
REQ-025 SHALL return from DONE to IDLE on an edge with out_ready=1; mul_ready SHALL therefore first reassert in the cycle after the handshake, with no back-to-back accept.
REQ-026 SHALL give a latency of 34 edges from accept to out_valid for 64-bit operations and 18 for mulw, excluding stall cycles in DONE.
REQ-027 SHALL, when flush=1, go to IDLE on the next edge from any state, drop the result, and not assert out_valid for the flushed operation.
REQ-028 SHALL let flush take priority over mul_valid and out_ready on the same edge.
REQ-029 SHALL ignore mul_valid while not in IDLE and leave the latched operands unchanged.

Reset
REQ-030 SHALL, on an edge with rst_n=0, force state=IDLE, counter=0, accumulator and shift registers=0, mul_ready=1, out_valid=0, result_hi=0, result_lo=0.
REQ-031 SHALL let a reset in BUSY or DONE abandon the operation with no out_valid.
REQ-032 SHALL give reset priority over flush and mul_valid.

Verification
REQ-033 SHALL check: signed 64-bit, X=-3, Y=7, mul_signed=11 -> after 34 edges out_valid=1, result_hi=0xFFFFFFFFFFFFFFFF, result_lo=0xFFFFFFFFFFFFFFEB.
REQ-034 SHALL check: unsigned, X=Y=0xFFFFFFFFFFFFFFFF, mul_signed=00 -> result_hi=0xFFFFFFFFFFFFFFFE, result_lo=0x0000000000000001.
REQ-035 SHALL check: mulw, X=0x7FFFFFFF, Y=2, mul_signed=11 -> after 18 edges result_lo=0xFFFFFFFFFFFFFFFE, result_hi=0.
REQ-036 SHALL check: signed-by-unsigned, X=-1, Y=0xFFFFFFFFFFFFFFFF, mul_signed=10 -> result_hi=0xFFFFFFFFFFFFFFFF, result_lo=0x0000000000000001.
REQ-037 SHALL check: flush at BUSY cycle 10 -> IDLE next edge, no out_valid; a new request 2 cycles later completes correctly.
REQ-038 SHALL check: out_ready=0 for 5 cycles in DONE -> out_valid and results held; rst_n=0 mid-BUSY -> all outputs at reset values next edge.

Source files
------------

// File: rtl/ysyx_22050854_mul_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_22050854_mul_ctrl
//   Iterative radix-4 Booth multiplier controller for an RV64 EXU.
//   A request is accepted in IDLE. The operands are extended to 66 bits, or to
//   34 bits for MULW. One Booth digit is then retired per BUSY cycle into a
//   132-bit accumulator. The product is presented in DONE until it is consumed.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   mul_valid    request strobe (accepted only in IDLE)
//   flush        abort any operation in flight
//   mulw         32-bit operation (result is sign-extended low word)
//   mul_signed   {multiplicand signed, multiplier signed}
//   multiplicand operand X
//   multiplier   operand Y
//   out_ready    consumer accepts the result
//   mul_ready    controller can accept a request (IDLE only)
//   out_valid    result_hi/result_lo valid (DONE only)
//   result_hi    upper 64 bits of the product (0 for mulw)
//   result_lo    lower 64 bits of the product
// ----------------------------------------------------------------------------
module ysyx_22050854_mul_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mul_valid,
    input  logic        flush,
    input  logic        mulw,
    input  logic [1:0]  mul_signed,
    input  logic [63:0] multiplicand,
    input  logic [63:0] multiplier,
    input  logic        out_ready,
    output logic        mul_ready,
    output logic        out_valid,
    output logic [63:0] result_hi,
    output logic [63:0] result_lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e         state_q;
    logic [5:0]     cnt_q;
    logic [131:0]   x_q;
    logic [66:0]    y_q;
    logic [131:0]   acc_q;
    logic           mulw_q;
    logic           mul_ready_q;
    logic           out_valid_q;
    logic [63:0]    res_hi_q;
    logic [63:0]    res_lo_q;

    // Operand extension. An unsigned multiplicand with a signed multiplier
    // (2'b01) has no RV64 use, so it is folded into the fully unsigned case.
    logic           x_sgn;
    logic           y_sgn;
    logic [65:0]    x_ext;
    logic [65:0]    y_ext;

    assign x_sgn = mul_signed[1];
    assign y_sgn = mul_signed[1] & mul_signed[0];

    // The 34-bit MULW extension is widened to 66 bits by sign extension. The
    // upper Booth digits are never consumed because only 17 iterations run.
    always_comb begin
        x_ext = '0;
        y_ext = '0;
        if (mulw) begin
            x_ext = {{34{x_sgn & multiplicand[31]}}, multiplicand[31:0]};
            y_ext = {{34{y_sgn & multiplier[31]}},   multiplier[31:0]};
        end else begin
            x_ext = {{2{x_sgn & multiplicand[63]}}, multiplicand};
            y_ext = {{2{y_sgn & multiplier[63]}},   multiplier};
        end
    end

    // Booth radix-4 partial-product generator. The window is
    // {y[i+1], y[i], y[i-1]}. A negative multiple is produced as its one's
    // complement, and the carry-in pc adds the missing +1.
    logic [131:0]   pp;
    logic           pc;

    always_comb begin
        pp = '0;
        pc = 1'b0;
        case (y_q[2:0])
            3'b001, 3'b010: pp = x_q;
            3'b011:         pp = {x_q[130:0], 1'b0};
            3'b100: begin
                pp = ~{x_q[130:0], 1'b0};
                pc = 1'b1;
            end
            3'b101, 3'b110: begin
                pp = ~x_q;
                pc = 1'b1;
            end
            default: pp = '0;
        endcase
    end

    logic [131:0]   acc_d;
    logic           last;
    logic [63:0]    res_hi_d;
    logic [63:0]    res_lo_d;

    assign acc_d    = acc_q + pp + {131'd0, pc};
    assign last     = mulw_q ? (cnt_q == 6'd16) : (cnt_q == 6'd32);
    assign res_hi_d = mulw_q ? '0 : acc_d[127:64];
    assign res_lo_d = mulw_q ? {{32{acc_d[31]}}, acc_d[31:0]} : acc_d[63:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            acc_q       <= '0;
            mulw_q      <= 1'b0;
            mul_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            res_hi_q    <= '0;
            res_lo_q    <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mul_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mul_valid) begin
                        x_q         <= {{66{x_ext[65]}}, x_ext};
                        y_q         <= {y_ext, 1'b0};
                        mulw_q      <= mulw;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        mul_ready_q <= 1'b0;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    x_q   <= {x_q[129:0], 2'b00};
                    y_q   <= {2'b00, y_q[66:2]};
                    cnt_q <= cnt_q + 6'd1;
                    if (last) begin
                        res_hi_q    <= res_hi_d;
                        res_lo_q    <= res_lo_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        mul_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    mul_ready_q <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mul_ready = mul_ready_q;
    assign out_valid = out_valid_q;
    assign result_hi = res_hi_q;
    assign result_lo = res_lo_q;

endmodule

// File: tb/tb_ysyx_22050854_mul_ctrl.sv
module tb_ysyx_22050854_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mul_valid;
    logic        flush;
    logic        mulw;
    logic [1:0]  mul_signed;
    logic [63:0] multiplicand;
    logic [63:0] multiplier;
    logic        out_ready;
    logic        mul_ready;
    logic        out_valid;
    logic [63:0] result_hi;
    logic [63:0] result_lo;

    int checks = 0;
    int errors = 0;

    ysyx_22050854_mul_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mul_valid    (mul_valid),
        .flush        (flush),
        .mulw         (mulw),
        .mul_signed   (mul_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_ready    (out_ready),
        .mul_ready    (mul_ready),
        .out_valid    (out_valid),
        .result_hi    (result_hi),
        .result_lo    (result_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        w;
        logic [1:0]  sg;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] exp_hi;
        logic [63:0] exp_lo;
        int          stall;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accepts one request and waits for out_valid. The edge count includes the
    // accept edge. The task then optionally stalls in DONE, checks the result,
    // and completes the handshake.
    task automatic run_vec(input vec_t v);
        int edges;
        int exp_lat;
        chk({v.name, "_ready_before"}, {63'd0, mul_ready}, 64'd1);
        mulw         = v.w;
        mul_signed   = v.sg;
        multiplicand = v.x;
        multiplier   = v.y;
        mul_valid    = 1'b1;
        step();
        mul_valid = 1'b0;
        edges = 1;
        chk({v.name, "_ready_busy"}, {63'd0, mul_ready}, 64'd0);
        while (!out_valid && edges < 80) begin
            step();
            edges++;
        end
        exp_lat = v.w ? 18 : 34;
        chk({v.name, "_latency"}, 64'(edges), 64'(exp_lat));
        chk({v.name, "_hi"}, result_hi, v.exp_hi);
        chk({v.name, "_lo"}, result_lo, v.exp_lo);
        for (int s = 0; s < v.stall; s++) begin
            step();
            chk({v.name, "_stall_valid"}, {63'd0, out_valid}, 64'd1);
            chk({v.name, "_stall_ready"}, {63'd0, mul_ready}, 64'd0);
            chk({v.name, "_stall_hi"}, result_hi, v.exp_hi);
            chk({v.name, "_stall_lo"}, result_lo, v.exp_lo);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({v.name, "_valid_after"}, {63'd0, out_valid}, 64'd0);
        chk({v.name, "_ready_after"}, {63'd0, mul_ready}, 64'd1);
    endtask

    initial begin
        vecs[0] = '{"s64_m3x7", 1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB, 0};
        vecs[1] = '{"u64_max_sq", 1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001, 5};
        vecs[2] = '{"mulw_7fff_x2", 1'b1, 2'b11, 64'h0000_0000_7FFF_FFFF, 64'd2,
                    64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 0};
        vecs[3] = '{"su_m1_xmax", 1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 0};
        vecs[4] = '{"u64_5x6", 1'b0, 2'b00, 64'd5, 64'd6, 64'h0, 64'd30, 0};
        vecs[5] = '{"ms01_as_u", 1'b0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                    64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 0};
        vecs[6] = '{"s64_min_sq", 1'b0, 2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    64'h4000_0000_0000_0000, 64'h0, 0};
        vecs[7] = '{"mulw_hi_junk", 1'b1, 2'b11, 64'hDEAD_BEEF_0000_0003, 64'h1234_5678_0000_0005,
                    64'h0, 64'h0000_0000_0000_000F, 0};
        vecs[8] = '{"mulw_u_max", 1'b1, 2'b00, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
                    64'h0, 64'h0000_0000_0000_0001, 0};
        vecs[9] = '{"mulw_s_m1sq", 1'b1, 2'b11, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
                    64'h0, 64'h0000_0000_0000_0001, 0};

        rst_n        = 1'b0;
        mul_valid    = 1'b0;
        flush        = 1'b0;
        mulw         = 1'b0;
        mul_signed   = 2'b00;
        multiplicand = '0;
        multiplier   = '0;
        out_ready    = 1'b0;
        step();
        step();
        chk("rst_ready", {63'd0, mul_ready}, 64'd1);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_hi", result_hi, 64'h0);
        chk("rst_lo", result_lo, 64'h0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Flush together with mul_valid in IDLE: the flush wins, so nothing is accepted.
        flush = 1'b1; mul_valid = 1'b1;
        step();
        flush = 1'b0; mul_valid = 1'b0;
        chk("flush_prio_ready", {63'd0, mul_ready}, 64'd1);

        // Flush during the 10th BUSY cycle.
        mulw = 1'b0; mul_signed = 2'b00; multiplicand = 64'd9; multiplier = 64'd9;
        mul_valid = 1'b1;
        step();
        mul_valid = 1'b0;
        for (int k = 0; k < 9; k++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_ready", {63'd0, mul_ready}, 64'd1);
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                if (k == 2) break;
                step();
                if (out_valid) seen++;
            end
            chk("flush_no_valid", 64'(seen), 64'd0);
        end
        run_vec(vecs[4]);

        // mul_valid while BUSY must be ignored, and the latched operands are kept.
        mulw = 1'b0; mul_signed = 2'b00; multiplicand = 64'd5; multiplier = 64'd6;
        mul_valid = 1'b1;
        step();
        multiplicand = 64'd7; multiplier = 64'd7;
        begin
            int edges;
            edges = 1;
            while (!out_valid && edges < 80) begin
                step();
                edges++;
            end
            mul_valid = 1'b0;
            chk("ignore_latency", 64'(edges), 64'd34);
            chk("ignore_lo", result_lo, 64'd30);
            chk("ignore_hi", result_hi, 64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ignore_ready_after", {63'd0, mul_ready}, 64'd1);

        // Flush while in DONE drops the result.
        run_vec(vecs[0]);
        mul_valid = 1'b1;
        step();
        mul_valid = 1'b0;
        while (!out_valid && checks < 100000) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_done_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_done_ready", {63'd0, mul_ready}, 64'd1);

        // Reset in the middle of BUSY.
        mulw = 1'b0; mul_signed = 2'b11; multiplicand = 64'd3; multiplier = 64'd3;
        mul_valid = 1'b1;
        step();
        mul_valid = 1'b0;
        for (int k = 0; k < 12; k++) step();
        rst_n = 1'b0; flush = 1'b1; mul_valid = 1'b1;
        step();
        rst_n = 1'b1; flush = 1'b0; mul_valid = 1'b0;
        chk("midrst_ready", {63'd0, mul_ready}, 64'd1);
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_hi", result_hi, 64'h0);
        chk("midrst_lo", result_lo, 64'h0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                step();
                if (out_valid) seen++;
            end
            chk("midrst_no_valid", 64'(seen), 64'd0);
        end
        run_vec(vecs[2]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
